neo_gfx_fetch: RTL and testbench
================================

# neo_gfx_fetch

Graphics ROM fetch sequencer directly downstream of the P-bus address latch (`neo_273`). It turns each sprite (C-ROM) and fix-layer (S-ROM) address strobe into a 32-bit read on a single shared memory port. Requests use a req/ack handshake. The block returns latched pixel words with one-cycle valid pulses to the line-buffer and fix serializers. C-ROM reads take priority over S-ROM reads; each channel is buffered one deep.

## Interface
Parameters: none.

- `CLK`  in  1  system clock
- `RESET`  in  1  asynchronous, active-high reset
- `C_LATCH`  in  20  sprite tile/line address from the P-bus latch
- `S_LATCH`  in  16  fix tile/line address from the P-bus latch
- `PCK1B_EN`  in  1  clock enable; same cycle the latch loads `C_LATCH`
- `PCK2B_EN`  in  1  clock enable; same cycle the latch loads `S_LATCH`
- `CA4`  in  1  sprite half select; sampled when `PCK1B_EN`=1
- `MEM_REQ`  out  1  read request, level
- `MEM_ADDR`  out  24  byte address, stable while `MEM_REQ`=1
- `MEM_ACK`  in  1  one-cycle pulse; `MEM_DATA` is valid in the same cycle
- `MEM_DATA`  in  32  read data
- `CR_DATA`  out  32  last C-ROM word
- `CR_VALID`  out  1  one-cycle pulse when `CR_DATA` updates
- `FIX_DATA`  out  32  last S-ROM word
- `FIX_VALID`  out  1  one-cycle pulse when `FIX_DATA` updates
- `OVR`  out  2  sticky overrun flags: bit0 = C, bit1 = S; cleared only by reset

## Operation
- Pending flags `c_pend` and `s_pend`:
  - Set at the clock edge where `PCK1B_EN` or `PCK2B_EN` is 1.
  - `CA4` is registered into `ca4_q` at the same edge as `c_pend`.
  - Addresses are not copied at strobe time. `C_LATCH` and `S_LATCH` hold their values until the next strobe and are read at issue.
- FSM states:
  - `IDLE`
    - `c_pend` set → `C_BUSY`: `MEM_ADDR`={1'b0, `C_LATCH`, `ca4_q`, 2'b00}, `MEM_REQ`←1, clear `c_pend`.
    - Otherwise `s_pend` set → `S_BUSY`: `MEM_ADDR`={1'b1, 5'b0, `S_LATCH`, 2'b00}, `MEM_REQ`←1, clear `s_pend`.
  - `C_BUSY` / `S_BUSY`: wait for `MEM_ACK`. On ack, load `MEM_DATA` into `CR_DATA` or `FIX_DATA`, pulse the matching valid, `MEM_REQ`←0, → `IDLE`.
- Overrun: a strobe arriving while that channel's pend flag is already set (not yet issued) sets the matching `OVR` bit. The pend flag stays set; the newer latch contents are used at issue.
- A strobe during that channel's own BUSY state sets pend with no overrun. The in-flight data is delivered, then the new request issues.
- A strobe in the same cycle its pend flag is cleared by issue: the pend flag ends set, no overrun.
- `MEM_ACK` in `IDLE` is ignored; data outputs and valids are unchanged.
- Reset values:
  - All outputs 0: `MEM_REQ`, `MEM_ADDR`, `CR_DATA`, `CR_VALID`, `FIX_DATA`, `FIX_VALID`, `OVR`=2'b00.
  - FSM `IDLE`, pend flags 0, `ca4_q` 0.
- Reset asserted mid-transaction forces the reset state immediately. An ack that arrives later is ignored.

## Timing
- Strobe at edge N → `MEM_REQ`=1 after edge N+1 (channel idle, no competing request).
- Ack at edge M → `CR_VALID`/`FIX_VALID`=1 for the single cycle after M; `MEM_REQ`=0 after M.
- Next request earliest at edge M+1. `MEM_REQ` is always low for at least one cycle between requests.
- Simultaneous `PCK1B_EN` and `PCK2B_EN`: C issues first, S issues at edge M+1 after C's ack.
- Minimum strobe-to-valid latency: 3 edges (strobe N, issue N+1, ack N+2 → valid after N+2).

## Test plan
- Reset, then `C_LATCH`=20'hABCDE, `CA4`=1, `PCK1B_EN` pulse; ack 2 cycles after `MEM_REQ` rises with `MEM_DATA`=32'h11223344 → `MEM_ADDR`=24'h55E6F4; `CR_DATA`=32'h11223344; one-cycle `CR_VALID`; `OVR`=0.
- Both strobes in the same cycle, `S_LATCH`=16'h1234 → C request first; after its ack, S request `MEM_ADDR`=24'h8048D0; `FIX_VALID` follows the S ack.
- Two `PCK1B_EN` strobes while an S request is in flight (C pend not yet issued) → `OVR`=2'b01; exactly one C request is issued, using the second `C_LATCH` value.
- `PCK1B_EN` during `C_BUSY` → the first word is delivered, then a second C request issues one cycle after the ack; `OVR` stays 0.
- `RESET` pulsed while `MEM_REQ`=1, then a stray `MEM_ACK` → all outputs 0; no valid pulse; FSM `IDLE`.
- `MEM_ACK` pulse with no request outstanding → `CR_DATA`/`FIX_DATA` unchanged; no valid pulse.

Source files
------------

// File: rtl/neo_gfx_fetch_if.sv
// neo_gfx_fetch_if
// Shared graphics ROM read port between the fetch sequencer and memory.
//
// Signals:
//   MEM_REQ   read request, level; held high until the matching ack
//   MEM_ADDR  byte address, stable for the whole time MEM_REQ is high
//   MEM_ACK   one-cycle completion pulse
//   MEM_DATA  read data, valid in the same cycle as MEM_ACK
//
// Handshake: the master raises MEM_REQ with MEM_ADDR and holds both steady.
// The slave answers with a single-cycle MEM_ACK carrying MEM_DATA. The master
// drops MEM_REQ on the cycle after the ack. An ack seen with no request
// outstanding carries no meaning and is dropped by the master.
interface neo_gfx_fetch_if;
    logic        MEM_REQ;
    logic [23:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_DATA;

    modport master (
        output MEM_REQ,
        output MEM_ADDR,
        input  MEM_ACK,
        input  MEM_DATA
    );

    modport slave (
        input  MEM_REQ,
        input  MEM_ADDR,
        output MEM_ACK,
        output MEM_DATA
    );
endinterface

// File: rtl/neo_gfx_fetch.sv
// neo_gfx_fetch
// Turns C-ROM (sprite) and S-ROM (fix) address strobes from the P-bus latch
// into 32-bit reads on one shared memory port. Each channel is buffered one
// request deep, and C requests win over S requests.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   C_LATCH, S_LATCH    latched sprite / fix addresses, read at issue time
//   PCK1B_EN, PCK2B_EN  strobes marking a new C / S address
//   CA4                 sprite half select, captured with PCK1B_EN
//   mem                 shared memory read port (req/ack)
//   CR_DATA, CR_VALID   last C-ROM word and its one-cycle update pulse
//   FIX_DATA, FIX_VALID last S-ROM word and its one-cycle update pulse
//   OVR                 sticky overrun flags {S, C}
//   DBG_STATE           current fetch FSM state
module neo_gfx_fetch (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [19:0]             C_LATCH,
    input  logic [15:0]             S_LATCH,
    input  logic                    PCK1B_EN,
    input  logic                    PCK2B_EN,
    input  logic                    CA4,
    neo_gfx_fetch_if.master         mem,
    output logic [31:0]             CR_DATA,
    output logic                    CR_VALID,
    output logic [31:0]             FIX_DATA,
    output logic                    FIX_VALID,
    output logic [1:0]              OVR,
    output logic [1:0]              DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_C_BUSY = 2'd1,
        ST_S_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_c_pend;
    logic        r_s_pend;
    logic        r_ca4;
    logic        r_req;
    logic [23:0] r_addr;
    logic [31:0] r_cr_data;
    logic        r_cr_valid;
    logic [31:0] r_fix_data;
    logic        r_fix_valid;
    logic [1:0]  r_ovr;

    state_t      w_state_nxt;
    logic        w_req_nxt;
    logic [23:0] w_addr_nxt;
    logic [31:0] w_cr_data_nxt;
    logic        w_cr_valid_nxt;
    logic [31:0] w_fix_data_nxt;
    logic        w_fix_valid_nxt;
    logic        w_issue_c;
    logic        w_issue_s;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_cr_data_nxt   = r_cr_data;
        w_cr_valid_nxt  = 1'b0;
        w_fix_data_nxt  = r_fix_data;
        w_fix_valid_nxt = 1'b0;
        w_issue_c       = 1'b0;
        w_issue_s       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Latches still hold the most recent strobe's address, so
                // they are sampled here rather than copied at strobe time.
                if (r_c_pend) begin
                    w_issue_c   = 1'b1;
                    w_state_nxt = ST_C_BUSY;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = {1'b0, C_LATCH, r_ca4, 2'b00};
                end else if (r_s_pend) begin
                    w_issue_s   = 1'b1;
                    w_state_nxt = ST_S_BUSY;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = {1'b1, 5'b0, S_LATCH, 2'b00};
                end
            end
            ST_C_BUSY: begin
                if (mem.MEM_ACK) begin
                    w_cr_data_nxt  = mem.MEM_DATA;
                    w_cr_valid_nxt = 1'b1;
                    w_req_nxt      = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_S_BUSY: begin
                if (mem.MEM_ACK) begin
                    w_fix_data_nxt  = mem.MEM_DATA;
                    w_fix_valid_nxt = 1'b1;
                    w_req_nxt       = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_addr      <= 24'h0;
            r_cr_data   <= 32'h0;
            r_cr_valid  <= 1'b0;
            r_fix_data  <= 32'h0;
            r_fix_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_cr_data   <= w_cr_data_nxt;
            r_cr_valid  <= w_cr_valid_nxt;
            r_fix_data  <= w_fix_data_nxt;
            r_fix_valid <= w_fix_valid_nxt;
        end
    end

    // A new strobe always wins over the issue-time clear, so a strobe landing
    // on the issue edge leaves a fresh request pending. Overrun only flags a
    // strobe that overwrites a request that never reached the memory port.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_c_pend <= 1'b0;
            r_s_pend <= 1'b0;
            r_ca4    <= 1'b0;
            r_ovr    <= 2'b00;
        end else begin
            if (PCK1B_EN) begin
                r_c_pend <= 1'b1;
                r_ca4    <= CA4;
            end else if (w_issue_c) begin
                r_c_pend <= 1'b0;
            end
            if (PCK2B_EN) begin
                r_s_pend <= 1'b1;
            end else if (w_issue_s) begin
                r_s_pend <= 1'b0;
            end
            if (PCK1B_EN && r_c_pend && !w_issue_c) begin
                r_ovr[0] <= 1'b1;
            end
            if (PCK2B_EN && r_s_pend && !w_issue_s) begin
                r_ovr[1] <= 1'b1;
            end
        end
    end

    assign mem.MEM_REQ  = r_req;
    assign mem.MEM_ADDR = r_addr;
    assign CR_DATA      = r_cr_data;
    assign CR_VALID     = r_cr_valid;
    assign FIX_DATA     = r_fix_data;
    assign FIX_VALID    = r_fix_valid;
    assign OVR          = r_ovr;
    assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_neo_gfx_fetch.sv
// tb_neo_gfx_fetch
// Directed bench for neo_gfx_fetch. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at that same point, so every sample
// shows the state registered by the preceding edge.
module tb_neo_gfx_fetch;

    logic        CLK;
    logic        RESET;
    logic [19:0] C_LATCH;
    logic [15:0] S_LATCH;
    logic        PCK1B_EN;
    logic        PCK2B_EN;
    logic        CA4;
    logic [31:0] CR_DATA;
    logic        CR_VALID;
    logic [31:0] FIX_DATA;
    logic        FIX_VALID;
    logic [1:0]  OVR;
    logic [1:0]  DBG_STATE;

    neo_gfx_fetch_if mem_if ();

    neo_gfx_fetch dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .C_LATCH   (C_LATCH),
        .S_LATCH   (S_LATCH),
        .PCK1B_EN  (PCK1B_EN),
        .PCK2B_EN  (PCK2B_EN),
        .CA4       (CA4),
        .mem       (mem_if),
        .CR_DATA   (CR_DATA),
        .CR_VALID  (CR_VALID),
        .FIX_DATA  (FIX_DATA),
        .FIX_VALID (FIX_VALID),
        .OVR       (OVR),
        .DBG_STATE (DBG_STATE)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Event counters sampled on the falling edge.
    int   cr_valid_cnt  = 0;
    int   fix_valid_cnt = 0;
    int   c_req_cnt     = 0;
    int   s_req_cnt     = 0;
    logic req_prev      = 1'b0;

    always @(negedge CLK) begin
        if (CR_VALID === 1'b1) cr_valid_cnt++;
        if (FIX_VALID === 1'b1) fix_valid_cnt++;
        if (mem_if.MEM_REQ === 1'b1 && req_prev !== 1'b1) begin
            if (mem_if.MEM_ADDR[23]) s_req_cnt++;
            else c_req_cnt++;
        end
        req_prev = mem_if.MEM_REQ;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET           = 1'b1;
        C_LATCH         = '0;
        S_LATCH         = '0;
        PCK1B_EN        = 1'b0;
        PCK2B_EN        = 1'b0;
        CA4             = 1'b0;
        mem_if.MEM_ACK  = 1'b0;
        mem_if.MEM_DATA = '0;
        tick();
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL reset_req got=%b want=0", mem_if.MEM_REQ);
        end
        n_cmp++;
        if (mem_if.MEM_ADDR !== 24'h0) begin
            n_err++; $display("FAIL reset_addr got=%h want=000000", mem_if.MEM_ADDR);
        end
        n_cmp++;
        if ({CR_DATA, FIX_DATA} !== 64'h0) begin
            n_err++; $display("FAIL reset_data got=%h/%h want=0/0", CR_DATA, FIX_DATA);
        end
        n_cmp++;
        if ({CR_VALID, FIX_VALID, OVR} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b want=0000", {CR_VALID, FIX_VALID, OVR});
        end
        n_cmp++;
        if (DBG_STATE !== 2'd0) begin
            n_err++; $display("FAIL reset_state got=%0d want=0", DBG_STATE);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_c_fetch;
        int v0;
        v0       = cr_valid_cnt;
        C_LATCH  = 20'hABCDE;
        CA4      = 1'b1;
        PCK1B_EN = 1'b1;
        tick();                       // strobe edge N
        PCK1B_EN = 1'b0;
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL c_req_early got=%b want=0", mem_if.MEM_REQ);
        end
        tick();                       // issue edge N+1
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1) begin
            n_err++; $display("FAIL c_req_rise got=%b want=1", mem_if.MEM_REQ);
        end
        n_cmp++;
        if (mem_if.MEM_ADDR !== 24'h55E6F4) begin
            n_err++; $display("FAIL c_addr got=%h want=55e6f4", mem_if.MEM_ADDR);
        end
        tick();
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'h11223344;
        tick();                       // ack edge
        mem_if.MEM_ACK  = 1'b0;
        n_cmp++;
        if (CR_VALID !== 1'b1 || CR_DATA !== 32'h11223344) begin
            n_err++; $display("FAIL c_data got=%b/%h want=1/11223344", CR_VALID, CR_DATA);
        end
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL c_req_drop got=%b want=0", mem_if.MEM_REQ);
        end
        tick();
        n_cmp++;
        if (CR_VALID !== 1'b0 || OVR !== 2'b00) begin
            n_err++; $display("FAIL c_valid_end got=%b ovr=%b want=0 ovr=00", CR_VALID, OVR);
        end
        n_cmp++;
        if (cr_valid_cnt - v0 !== 1) begin
            n_err++; $display("FAIL c_valid_pulses got=%0d want=1", cr_valid_cnt - v0);
        end
    endtask

    task automatic test_both;
        C_LATCH  = 20'h01234;
        CA4      = 1'b0;
        S_LATCH  = 16'h1234;
        PCK1B_EN = 1'b1;
        PCK2B_EN = 1'b1;
        tick();
        PCK1B_EN = 1'b0;
        PCK2B_EN = 1'b0;
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1 || mem_if.MEM_ADDR !== 24'h0091A0) begin
            n_err++; $display("FAIL both_c_first got=%b/%h want=1/0091a0", mem_if.MEM_REQ, mem_if.MEM_ADDR);
        end
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'hCAFE0001;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        n_cmp++;
        if (CR_VALID !== 1'b1 || FIX_VALID !== 1'b0 || mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL both_c_ack got=%b%b%b want=100", CR_VALID, FIX_VALID, mem_if.MEM_REQ);
        end
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1 || mem_if.MEM_ADDR !== 24'h8048D0) begin
            n_err++; $display("FAIL both_s_issue got=%b/%h want=1/8048d0", mem_if.MEM_REQ, mem_if.MEM_ADDR);
        end
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'h55AA1234;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        n_cmp++;
        if (FIX_VALID !== 1'b1 || FIX_DATA !== 32'h55AA1234 || CR_DATA !== 32'hCAFE0001) begin
            n_err++; $display("FAIL both_s_data got=%b/%h cr=%h want=1/55aa1234 cr=cafe0001", FIX_VALID, FIX_DATA, CR_DATA);
        end
        tick();
    endtask

    task automatic test_busy_strobe;
        C_LATCH  = 20'h0000F;
        CA4      = 1'b0;
        PCK1B_EN = 1'b1;
        tick();
        PCK1B_EN = 1'b0;
        tick();
        n_cmp++;
        if (mem_if.MEM_ADDR !== 24'h000078 || DBG_STATE !== 2'd1) begin
            n_err++; $display("FAIL busy_first got=%h st=%0d want=000078 st=1", mem_if.MEM_ADDR, DBG_STATE);
        end
        C_LATCH  = 20'h00010;
        PCK1B_EN = 1'b1;              // strobe during C_BUSY
        tick();
        PCK1B_EN = 1'b0;
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'hA0A0A0A0;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        n_cmp++;
        if (CR_VALID !== 1'b1 || CR_DATA !== 32'hA0A0A0A0 || mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL busy_first_data got=%b/%h req=%b want=1/a0a0a0a0 req=0", CR_VALID, CR_DATA, mem_if.MEM_REQ);
        end
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1 || mem_if.MEM_ADDR !== 24'h000080) begin
            n_err++; $display("FAIL busy_second_issue got=%b/%h want=1/000080", mem_if.MEM_REQ, mem_if.MEM_ADDR);
        end
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'hB0B0B0B0;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        n_cmp++;
        if (CR_DATA !== 32'hB0B0B0B0 || OVR !== 2'b00) begin
            n_err++; $display("FAIL busy_second_data got=%h ovr=%b want=b0b0b0b0 ovr=00", CR_DATA, OVR);
        end
        tick();
    endtask

    task automatic test_idle_ack;
        int v0;
        int f0;
        v0 = cr_valid_cnt;
        f0 = fix_valid_cnt;
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'hDEADBEEF;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        tick();
        n_cmp++;
        if (CR_DATA !== 32'hB0B0B0B0 || FIX_DATA !== 32'h55AA1234) begin
            n_err++; $display("FAIL idle_ack_data got=%h/%h want=b0b0b0b0/55aa1234", CR_DATA, FIX_DATA);
        end
        n_cmp++;
        if (cr_valid_cnt != v0 || fix_valid_cnt != f0 || mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL idle_ack_pulse got=%0d/%0d req=%b want=0/0 req=0", cr_valid_cnt - v0, fix_valid_cnt - f0, mem_if.MEM_REQ);
        end
    endtask

    task automatic test_overrun;
        int c0;
        c0       = c_req_cnt;
        S_LATCH  = 16'h00FF;
        PCK2B_EN = 1'b1;
        tick();
        PCK2B_EN = 1'b0;
        tick();
        n_cmp++;
        if (mem_if.MEM_ADDR !== 24'h8003FC || DBG_STATE !== 2'd2) begin
            n_err++; $display("FAIL ovr_s_issue got=%h st=%0d want=8003fc st=2", mem_if.MEM_ADDR, DBG_STATE);
        end
        C_LATCH  = 20'h11111;
        CA4      = 1'b0;
        PCK1B_EN = 1'b1;
        tick();
        n_cmp++;
        if (OVR !== 2'b00) begin
            n_err++; $display("FAIL ovr_first_strobe got=%b want=00", OVR);
        end
        C_LATCH  = 20'h22222;
        CA4      = 1'b1;
        tick();
        PCK1B_EN = 1'b0;
        n_cmp++;
        if (OVR !== 2'b01) begin
            n_err++; $display("FAIL ovr_flag got=%b want=01", OVR);
        end
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'h0F0F0F0F;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1 || mem_if.MEM_ADDR !== 24'h111114) begin
            n_err++; $display("FAIL ovr_c_issue got=%b/%h want=1/111114", mem_if.MEM_REQ, mem_if.MEM_ADDR);
        end
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'h12345678;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (c_req_cnt - c0 !== 1 || mem_if.MEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL ovr_c_req_count got=%0d req=%b want=1 req=0", c_req_cnt - c0, mem_if.MEM_REQ);
        end
        n_cmp++;
        if (CR_DATA !== 32'h12345678 || OVR !== 2'b01) begin
            n_err++; $display("FAIL ovr_final got=%h ovr=%b want=12345678 ovr=01", CR_DATA, OVR);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        C_LATCH  = 20'h00001;
        CA4      = 1'b0;
        PCK1B_EN = 1'b1;
        tick();
        PCK1B_EN = 1'b0;
        tick();
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_req got=%b want=1", mem_if.MEM_REQ);
        end
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b0 || mem_if.MEM_ADDR !== 24'h0 || OVR !== 2'b00 || DBG_STATE !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_async got=%b/%h ovr=%b st=%0d want=0/000000 ovr=00 st=0", mem_if.MEM_REQ, mem_if.MEM_ADDR, OVR, DBG_STATE);
        end
        tick();
        RESET = 1'b0;
        v0    = cr_valid_cnt;
        mem_if.MEM_ACK  = 1'b1;
        mem_if.MEM_DATA = 32'hFFFFFFFF;
        tick();
        mem_if.MEM_ACK  = 1'b0;
        tick();
        n_cmp++;
        if (CR_DATA !== 32'h0 || FIX_DATA !== 32'h0 || cr_valid_cnt != v0) begin
            n_err++; $display("FAIL rst_mid_stray_ack got=%h/%h pulses=%0d want=0/0 pulses=0", CR_DATA, FIX_DATA, cr_valid_cnt - v0);
        end
        n_cmp++;
        if (mem_if.MEM_REQ !== 1'b0 || DBG_STATE !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_idle got=%b st=%0d want=0 st=0", mem_if.MEM_REQ, DBG_STATE);
        end
    endtask

    initial begin
        test_reset();
        test_c_fetch();
        test_both();
        test_busy_strobe();
        test_idle_ack();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
